ext_pipe: RTL

Parametrised, registered immediate/load-data extender for the pipelined MIPS datapath. It replaces the purely combinational immediate extender at the ID/EX and MEM/WB boundaries. It accepts one request per cycle over a valid/ready handshake and performs one of eight extension modes: four immediate forms and four byte/halfword load forms. Results are returned one cycle later through a two-entry skid buffer, so back-pressure never drops or duplicates data.

---
 rtl/ext_pkg.sv | 22 ++
 rtl/ext_core.sv | 48 ++++
 rtl/ext_pipe.sv | 98 +++++++++
 3 files changed

// File: rtl/ext_pkg.sv
// Shared encodings for the immediate/load-data extender.
package ext_pkg;

  localparam logic [2:0] EXT_SIGN = 3'b000;
  localparam logic [2:0] EXT_ZERO = 3'b001;
  localparam logic [2:0] EXT_LUI  = 3'b010;
  localparam logic [2:0] EXT_BR   = 3'b011;
  localparam logic [2:0] EXT_LB   = 3'b100;
  localparam logic [2:0] EXT_LBU  = 3'b101;
  localparam logic [2:0] EXT_LH   = 3'b110;
  localparam logic [2:0] EXT_LHU  = 3'b111;

  localparam int EXT_DATA_W = 32;

  // Result record at the default datapath width; wider instances use a
  // module-local record with the same field order.
  typedef struct packed {
    logic [EXT_DATA_W-1:0] ext;
    logic                  err;
  } ext_res_t;

endpackage

// File: rtl/ext_core.sv
// Combinational mode decode and immediate/byte/halfword extraction.
module ext_core
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHIFT  = 2,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [2:0]        i_eop,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [DATA_W-1:0] i_word,
  input  logic [OFF_W-1:0]  i_off,
  output logic [DATA_W-1:0] o_ext,
  output logic              o_err
);

  logic [DATA_W-1:0] w_sx;
  logic [DATA_W-1:0] w_zx;
  logic [OFF_W-1:0]  w_hidx;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  assign w_sx   = DATA_W'($signed(i_imm));
  assign w_zx   = DATA_W'(i_imm);
  // Halfword index drops off[0]; misalignment is reported, not corrected.
  assign w_hidx = i_off >> 1;
  assign w_byte = 8'(i_word >> {i_off, 3'b000});
  assign w_half = 16'(i_word >> {w_hidx, 4'b0000});

  always_comb begin
    o_ext = '0;
    case (i_eop)
      EXT_SIGN: o_ext = w_sx;
      EXT_ZERO: o_ext = w_zx;
      EXT_LUI:  o_ext = w_zx << (DATA_W - IMM_W);
      EXT_BR:   o_ext = w_sx << SHIFT;
      EXT_LB:   o_ext = DATA_W'($signed(w_byte));
      EXT_LBU:  o_ext = DATA_W'(w_byte);
      EXT_LH:   o_ext = DATA_W'($signed(w_half));
      EXT_LHU:  o_ext = DATA_W'(w_half);
      default:  o_ext = '0;
    endcase
  end

  assign o_err = i_eop[2] & i_eop[1] & i_off[0];

endmodule

// File: rtl/ext_pipe.sv
// Registered extender: ext_core followed by a two-entry skid buffer (M drives outputs, S absorbs one stall).
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = EXT_DATA_W,
  parameter int SHIFT  = 2,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        eop,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] word,
  input  logic [OFF_W-1:0]  off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext,
  output logic              err,
  output logic [15:0]       err_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] ext;
    logic              err;
  } res_t;

  res_t        w_res;
  res_t        r_m;
  res_t        r_s;
  logic        r_m_vld;
  logic        r_s_vld;
  logic [15:0] r_err_cnt;
  logic        w_in_xfer;
  logic        w_out_xfer;

  ext_core #(
    .IMM_W (IMM_W),
    .DATA_W(DATA_W),
    .SHIFT (SHIFT),
    .OFF_W (OFF_W)
  ) u_core (
    .i_eop (eop),
    .i_imm (imm),
    .i_word(word),
    .i_off (off),
    .o_ext (w_res.ext),
    .o_err (w_res.err)
  );

  // in_ready comes straight from the S valid flop, so out_ready never reaches it.
  assign in_ready   = !r_s_vld;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_m_vld & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m     <= '0;
      r_s     <= '0;
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
    end else begin
      if (w_out_xfer) begin
        if (r_s_vld) begin
          r_m     <= r_s;
          r_s_vld <= 1'b0;
        end else begin
          r_m_vld <= 1'b0;
        end
      end
      // S is always empty on an input transfer, so draining M alone frees it.
      if (w_in_xfer) begin
        if (!r_m_vld || w_out_xfer) begin
          r_m     <= w_res;
          r_m_vld <= 1'b1;
        end else begin
          r_s     <= w_res;
          r_s_vld <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (w_in_xfer && w_res.err && r_err_cnt != 16'hFFFF)
      r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign out_valid = r_m_vld;
  assign ext       = r_m.ext;
  assign err       = r_m.err;
  assign err_cnt   = r_err_cnt;

endmodule
